// File: rtl/buzzer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : buzzer_sequencer
// Purpose  : Fixed-priority arbiter and tone sequencer for the single board
//            buzzer. Three event classes (place, error, win) each hold a
//            one-deep pending flag. One sound plays at a time and is followed
//            by a silent gap. Tone and duration are timed by 2 kHz and 100 Hz
//            tick enables.
// Ports    : clk, rst_n      - clock, asynchronous active-low reset
//            enable          - power switch; low mutes and flushes everything
//            tick_2k         - 2 kHz one-clock tick (tone timing)
//            tick_100hz      - 100 Hz one-clock tick (duration timing)
//            req_place/error/win - one-clock request pulses
//            buzzer_out      - square wave to the buzzer pin
//            busy            - high while a sound or its gap is in progress
//            playing         - class playing: 0 none, 1 place, 2 error, 3 win
//            done            - one-clock pulse when a sound ends normally
// Options  : BUZZER_PREEMPT_EN - when defined, a pending higher class cuts off
//            the sound currently playing.
// Revision : 1.0 - initial release
// ============================================================================
module buzzer_sequencer #(
    parameter int HI_HALF      = 1,
    parameter int LO_HALF      = 2,
    parameter int PLACE_LEN    = 10,
    parameter int ERR_LEN      = 30,
    parameter int WIN_NOTE_LEN = 15,
    parameter int WIN_NOTES    = 4,
    parameter int GAP_LEN      = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       tick_2k,
    input  logic       tick_100hz,
    input  logic       req_place,
    input  logic       req_error,
    input  logic       req_win,
    output logic       buzzer_out,
    output logic       busy,
    output logic [1:0] playing,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam logic [1:0] C_NONE  = 2'd0;
    localparam logic [1:0] C_PLACE = 2'd1;
    localparam logic [1:0] C_ERROR = 2'd2;
    localparam logic [1:0] C_WIN   = 2'd3;

    localparam logic [3:0] C_HI_LAST    = 4'(HI_HALF - 1);
    localparam logic [3:0] C_LO_LAST    = 4'(LO_HALF - 1);
    localparam logic [7:0] C_PLACE_LAST = 8'(PLACE_LEN - 1);
    localparam logic [7:0] C_ERR_LAST   = 8'(ERR_LEN - 1);
    localparam logic [7:0] C_NOTE_LAST  = 8'(WIN_NOTE_LEN - 1);
    localparam logic [7:0] C_GAP_LAST   = 8'(GAP_LEN - 1);
    localparam logic [2:0] C_NOTES_LAST = 3'(WIN_NOTES - 1);

    state_t     state_q, state_d;
    logic [2:0] pend_q, pend_d;     // [0] place, [1] error, [2] win
    logic [1:0] cls_q, cls_d;
    logic [3:0] tone_q, tone_d;
    logic [7:0] dur_q, dur_d;       // note/sound length, reused as gap length
    logic [2:0] note_q, note_d;
    logic       buzz_q, buzz_d;
    logic       done_q, done_d;

    logic [2:0] w_req;
    logic [1:0] w_top;
    logic [2:0] w_top_mask;
    logic       w_hi_pitch;
    logic [3:0] w_half_last;
    logic [7:0] w_len_last;
    logic       w_preempt;

    // Highest pending class, pitch and length of what is playing now.
    always_comb begin
        w_req = {req_win, req_error, req_place};

        if (pend_q[2])      w_top = C_WIN;
        else if (pend_q[1]) w_top = C_ERROR;
        else if (pend_q[0]) w_top = C_PLACE;
        else                w_top = C_NONE;

        w_top_mask = 3'b000;
        if (w_top != C_NONE) w_top_mask = 3'b001 << (w_top - 2'd1);

        case (cls_q)
            C_PLACE: w_hi_pitch = 1'b1;
            C_ERROR: w_hi_pitch = 1'b0;
            default: w_hi_pitch = ~note_q[0];   // win alternates hi/lo by note
        endcase
        w_half_last = w_hi_pitch ? C_HI_LAST : C_LO_LAST;

        case (cls_q)
            C_PLACE: w_len_last = C_PLACE_LAST;
            C_ERROR: w_len_last = C_ERR_LAST;
            default: w_len_last = C_NOTE_LAST;
        endcase

`ifdef BUZZER_PREEMPT_EN
        w_preempt = (w_top > cls_q);
`else
        w_preempt = 1'b0;
`endif
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        cls_d   = cls_q;
        tone_d  = tone_q;
        dur_d   = dur_q;
        note_d  = note_q;
        buzz_d  = buzz_q;
        done_d  = 1'b0;

        if (!enable) begin
            // Power off: flush everything, requests ignored.
            state_d = S_IDLE;
            pend_d  = 3'b000;
            cls_d   = C_NONE;
            tone_d  = 4'd0;
            dur_d   = 8'd0;
            note_d  = 3'd0;
            buzz_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_top != C_NONE) begin
                        state_d = S_PLAY;
                        cls_d   = w_top;
                        pend_d  = pend_q & ~w_top_mask;
                        tone_d  = 4'd0;
                        dur_d   = 8'd0;
                        note_d  = 3'd0;
                        buzz_d  = 1'b0;
                    end
                end
                S_PLAY: begin
                    if (w_preempt) begin
                        // Drop the current sound and start the higher one cleanly.
                        cls_d  = w_top;
                        pend_d = pend_q & ~w_top_mask;
                        tone_d = 4'd0;
                        dur_d  = 8'd0;
                        note_d = 3'd0;
                        buzz_d = 1'b0;
                    end else begin
                        if (tick_2k) begin
                            if (tone_q == w_half_last) begin
                                buzz_d = ~buzz_q;
                                tone_d = 4'd0;
                            end else begin
                                tone_d = tone_q + 4'd1;
                            end
                        end
                        if (tick_100hz) begin
                            if (dur_q == w_len_last) begin
                                if (cls_q == C_WIN && note_q != C_NOTES_LAST) begin
                                    // Next note: restart the tone phase at the new
                                    // pitch, keeping the pin level continuous.
                                    note_d = note_q + 3'd1;
                                    dur_d  = 8'd0;
                                    tone_d = 4'd0;
                                    buzz_d = buzz_q;
                                end else begin
                                    state_d = S_GAP;
                                    done_d  = 1'b1;
                                    buzz_d  = 1'b0;
                                    cls_d   = C_NONE;
                                    tone_d  = 4'd0;
                                    dur_d   = 8'd0;
                                    note_d  = 3'd0;
                                end
                            end else begin
                                dur_d = dur_q + 8'd1;
                            end
                        end
                    end
                end
                S_GAP: begin
                    if (tick_100hz) begin
                        if (dur_q == C_GAP_LAST) begin
                            state_d = S_IDLE;
                            dur_d   = 8'd0;
                        end else begin
                            dur_d = dur_q + 8'd1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
            // A request in the grant cycle re-arms its flag for a later replay.
            pend_d = pend_d | w_req;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pend_q  <= 3'b000;
            cls_q   <= C_NONE;
            tone_q  <= 4'd0;
            dur_q   <= 8'd0;
            note_q  <= 3'd0;
            buzz_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            cls_q   <= cls_d;
            tone_q  <= tone_d;
            dur_q   <= dur_d;
            note_q  <= note_d;
            buzz_q  <= buzz_d;
            done_q  <= done_d;
        end
    end

    // In IDLE the class about to be granted is shown in the grant cycle itself.
    always_comb begin
        case (state_q)
            S_IDLE:  playing = enable ? w_top : C_NONE;
            S_PLAY:  playing = cls_q;
            default: playing = C_NONE;
        endcase
    end

    assign buzzer_out = buzz_q;
    assign busy       = (state_q == S_PLAY) || (state_q == S_GAP);
    assign done       = done_q;

endmodule
`default_nettype wire

// File: doc/buzzer_sequencer.md
Name: buzzer_sequencer

Overview:
Arbiter and sequencer for the single on-board buzzer. Three game event sources request sounds: stone placed, illegal move, and win. The block grants one sound at a time by fixed priority and generates the square-wave tone and its duration. It sits between the game FSM and the buzzer pin, and is timed by 2 kHz and 100 Hz tick enables from the clock generator.

Parameters:
HI_HALF, 1, tick_2k periods per half-cycle of the high tone (1 kHz at default)
LO_HALF, 2, tick_2k periods per half-cycle of the low tone (500 Hz at default)
PLACE_LEN, 10, place beep length in tick_100hz units (100 ms)
ERR_LEN, 30, error tone length in tick_100hz units
WIN_NOTE_LEN, 15, length of each win note in tick_100hz units
WIN_NOTES, 4, number of notes in the win melody (1..8)
GAP_LEN, 5, silent gap after each sound in tick_100hz units (must be ≥1)

Ports:
clk  input  1  system clock, 50 MHz
rst_n  input  1  asynchronous reset, active low
enable  input  1  power switch; low means mute and flush
tick_2k  input  1  one-clk pulse at 2 kHz
tick_100hz  input  1  one-clk pulse at 100 Hz
req_place  input  1  one-clk request pulse: place sound
req_error  input  1  one-clk request pulse: error sound
req_win  input  1  one-clk request pulse: win melody
buzzer_out  output  1  square wave to the buzzer pin
busy  output  1  high in PLAY or GAP
playing  output  2  class now playing: 0 none, 1 place, 2 error, 3 win
done  output  1  one-clk pulse when a sound completes normally

Behaviour:
- Reset: state IDLE, all pending flags clear, all counters 0. Outputs: buzzer_out=0, busy=0, playing=0, done=0.
- Pending flags: one per class, each one deep.
  - A request pulse sets its flag in any state while enable=1.
  - A flag clears when its class is granted.
  - Repeated requests before the grant collapse into one.
- Priority: win > error > place.
- States:
  - IDLE: if any flag is set, grant the highest class, go to PLAY next cycle, and set playing in that same cycle. A request pulsed at cycle t is therefore granted at t+1 and PLAY begins at t+2.
  - PLAY:
    - Tone counter counts tick_2k; buzzer_out toggles when the counter reaches HALF-1 on a tick, then the counter resets.
    - buzzer_out is 0 on the first PLAY cycle.
    - The duration counter counts tick_100hz.
    - Place and error end when the duration counter reaches LEN-1 on a tick.
    - Win: at each note end, if note_idx < WIN_NOTES-1, increment note_idx, clear the duration counter and swap pitch. Otherwise the melody ends. Even notes use the high tone, odd notes the low tone.
    - Place uses the high tone; error uses the low tone.
    - On end: done=1 for one clk, buzzer_out=0, playing=0, go to GAP.
  - GAP: silent for GAP_LEN tick_100hz ticks, then IDLE. Requests still latch during GAP.
- Same-class request while that class is playing: sets its flag, so the sound replays once after the gap.
- Simultaneous requests in one cycle: all flags are set; the highest class is granted and the rest wait.
- Counter widths: duration 8 bits, note_idx 3 bits, tone 4 bits. No wrap occurs within legal parameter ranges.
- enable=0, any state, synchronous: next cycle go to IDLE, clear all flags and counters, buzzer_out=0, playing=0, no done pulse. Requests are ignored while enable=0.
- Reset mid-sound: immediate silence and all state cleared.

Optional Feature:
BUZZER_PREEMPT_EN
- Defined: in PLAY, a pending class higher than the one playing preempts it.
  - Next cycle: the tone, duration and note counters clear, the higher class is granted, and playing updates.
  - The preempted class is dropped, not resumed, and no done pulse is issued for it.
  - No GAP is inserted before the preempting sound.
- Undefined: no preemption. A higher-class request waits until the current sound and its GAP finish.

Test Plan:
- Reset, then req_place at cycle t:
  - playing=1 at t+1; buzzer_out toggles every 2k tick (1 kHz).
  - done after 10 100 Hz ticks, then busy stays high for 5 more ticks, then busy=0.
- req_place, req_error and req_win in the same cycle:
  - sounds play in the order win (4 notes, pitch hi/lo/hi/lo), error, place.
  - 3 done pulses, each followed by a gap.
- req_error mid-place:
  - with BUZZER_PREEMPT_EN: playing goes 1→2 the next cycle, exactly 1 done pulse, place is never completed.
  - without it: place completes, GAP, then error plays.
- Three req_place pulses during one place sound → exactly one replay after the gap; 2 done pulses total.
- enable dropped mid-win melody with error pending:
  - next cycle buzzer_out=0, playing=0, busy=0, no done pulse.
  - after enable returns high, no sound plays.
- rst_n asserted mid-error tone → all outputs 0 asynchronously; idle after release.
